dll_tx_seq_ctrl: RTL and testbench

Transmit-side data-link-layer sequencer sitting directly upstream of the replay buffer. It accepts 64-bit TLP words from the transaction layer and assigns 12-bit sequence numbers. It drives the replay buffer's write port (`rb_we`, `rb_seq`, `rb_din`), processes incoming ACK/NAK DLLPs, and runs the replay timer. It orders replays (`rb_ack_nak`, `rb_timeout`) and escalates to link retrain when the replay count rolls over.

---
 rtl/dll_pkg.sv | 24 ++
 rtl/replay_timer.sv | 40 ++++
 rtl/dll_tx_seq_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_dll_tx_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// Shared types and helpers for the transmit-side data-link-layer sequencer.
package dll_pkg;

  // Sequence numbers are 12 bits; every sequence comparison wraps at 4096.
  localparam int SEQ_BITS = 12;

  // DLLP type codes carried on dllp_type; all other codes are ignored.
  localparam logic [1:0] DLLP_ACK = 2'b01;
  localparam logic [1:0] DLLP_NAK = 2'b10;

  // Sequencer states: normal transmit, replay readout, waiting on link retrain.
  typedef enum logic [1:0] {
    ST_SEND    = 2'd0,
    ST_REPLAY  = 2'd1,
    ST_RETRAIN = 2'd2
  } tx_state_t;

  // Forward distance from b to a, modulo 4096.
  function automatic logic [SEQ_BITS-1:0] seq_dist(input logic [SEQ_BITS-1:0] a,
                                                   input logic [SEQ_BITS-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timer: counts enabled cycles and emits a one-cycle expiry pulse
// on the LIMIT-th enabled cycle, then restarts from zero. Clear has priority.
module replay_timer #(
  parameter int LIMIT = 711
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and expiry decode.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        expire_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dll_tx_seq_ctrl.sv
// Transmit-side DLL sequencer: numbers outgoing TLP words, writes them to the
// replay buffer, retires them on ACK, replays on NAK or timer expiry and
// escalates to link retrain once the replay budget is spent.
//
// Handshake: a TLP word transfers on any rising edge where tlp_valid and
// tlp_ready are both high; tlp_ready never depends on tlp_valid, and the
// transferred word appears on the replay-buffer write port one cycle later.
module dll_tx_seq_ctrl
  import dll_pkg::*;
#(
  parameter int DATA_W             = 64,
  parameter int SEQ_W              = SEQ_BITS,
  parameter int DEPTH              = 1024,
  parameter int REPLAY_TIMER_LIMIT = 711,
  parameter int REPLAY_NUM_MAX     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tlp_valid,
  input  logic [DATA_W-1:0] tlp_data,
  output logic              tlp_ready,
  input  logic              dllp_valid,
  input  logic [1:0]        dllp_type,
  input  logic [SEQ_W-1:0]  dllp_seq,
  input  logic              retrain_done,
  output logic              rb_we,
  output logic [SEQ_W-1:0]  rb_seq,
  output logic [DATA_W-1:0] rb_din,
  output logic [1:0]        rb_ack_nak,
  output logic              rb_timeout,
  output logic              retrain_req,
  output logic              replay_active,
  output logic [10:0]       unacked,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_replay_num
);

  localparam logic [SEQ_W-1:0] DEPTH_S = SEQ_W'(DEPTH);
  localparam logic [1:0]       RN_MAX  = 2'(REPLAY_NUM_MAX);

  tx_state_t         state_q, state_d;
  logic [SEQ_W-1:0]  next_seq_q, next_seq_d;
  logic [SEQ_W-1:0]  ackd_seq_q, ackd_seq_d;
  logic [SEQ_W-1:0]  rp_q, rp_d;
  logic [1:0]        replay_num_q, replay_num_d;
  logic              pend_valid_q, pend_valid_d;
  logic [1:0]        pend_type_q, pend_type_d;
  logic [SEQ_W-1:0]  pend_seq_q, pend_seq_d;
  logic              rb_we_q, rb_we_d;
  logic [SEQ_W-1:0]  rb_seq_q, rb_seq_d;
  logic [DATA_W-1:0] rb_din_q, rb_din_d;
  logic [1:0]        rb_ack_nak_q, rb_ack_nak_d;
  logic              rb_timeout_q, rb_timeout_d;
  logic              retrain_req_q, retrain_req_d;
  logic              replay_active_q, replay_active_d;

  logic [SEQ_W-1:0]  unacked_full;
  logic              accept;
  logic              live_dllp;
  logic              ev_valid;
  logic [1:0]        ev_type;
  logic [SEQ_W-1:0]  ev_seq;
  logic [SEQ_W-1:0]  ev_dist;
  logic              ev_ok;
  logic              ack_adv;
  logic              nak;
  logic              timer_clear;
  logic              timer_en;
  logic              timer_expire;
  logic              timeout_ev;
  logic              escalate;

  // Event decode: outstanding count, TLP accept, DLLP selection/validation, timer control.
  always_comb begin
    unacked_full = seq_dist(next_seq_q, ackd_seq_q + SEQ_W'(1));
    tlp_ready    = (state_q == ST_SEND) && (unacked_full < DEPTH_S);
    accept       = tlp_valid && tlp_ready;
    // Only ACK/NAK codes are worth acting on or parking in the pending slot.
    live_dllp    = dllp_valid && ((dllp_type == DLLP_ACK) || (dllp_type == DLLP_NAK));
    // A fresh DLLP is newer than anything parked, so it takes precedence.
    ev_valid     = live_dllp || pend_valid_q;
    ev_type      = live_dllp ? dllp_type : pend_type_q;
    ev_seq       = live_dllp ? dllp_seq  : pend_seq_q;
    ev_dist      = seq_dist(ev_seq, ackd_seq_q);
    ev_ok        = (state_q == ST_SEND) && ev_valid && (ev_dist <= unacked_full);
    ack_adv      = ev_ok && (ev_type == DLLP_ACK) && (ev_dist != '0);
    nak          = ev_ok && (ev_type == DLLP_NAK);
    timer_clear  = (state_q != ST_SEND) || (unacked_full == '0) || ack_adv;
    timer_en     = (state_q == ST_SEND);
    // A NAK in the same cycle absorbs the expiry into its own escalation.
    timeout_ev   = timer_expire && !nak;
    escalate     = nak || timeout_ev;
  end

  replay_timer #(
    .LIMIT (REPLAY_TIMER_LIMIT)
  ) u_replay_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (timer_clear),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d         = state_q;
    next_seq_d      = next_seq_q;
    ackd_seq_d      = ackd_seq_q;
    rp_d            = rp_q;
    replay_num_d    = replay_num_q;
    pend_valid_d    = pend_valid_q;
    pend_type_d     = pend_type_q;
    pend_seq_d      = pend_seq_q;
    rb_we_d         = 1'b0;
    rb_seq_d        = rb_seq_q;
    rb_din_d        = rb_din_q;
    rb_ack_nak_d    = 2'b00;
    rb_timeout_d    = 1'b0;
    retrain_req_d   = 1'b0;
    replay_active_d = 1'b0;

    case (state_q)
      ST_SEND: begin
        pend_valid_d = 1'b0;
        if (accept) begin
          rb_we_d    = 1'b1;
          rb_seq_d   = next_seq_q;
          rb_din_d   = tlp_data;
          next_seq_d = next_seq_q + SEQ_W'(1);
        end
        if (ack_adv) begin
          ackd_seq_d   = ev_seq;
          replay_num_d = '0;
        end
        if (nak) begin
          ackd_seq_d = ev_seq;
        end
        if (timeout_ev) begin
          rb_timeout_d = 1'b1;
        end
        if (escalate) begin
          if (replay_num_q == RN_MAX) begin
            state_d       = ST_RETRAIN;
            retrain_req_d = 1'b1;
          end else begin
            replay_num_d = replay_num_q + 2'd1;
            rp_d         = ackd_seq_d + SEQ_W'(1);
            // Nothing left to replay: stay in SEND rather than an empty REPLAY.
            if (rp_d != next_seq_d) state_d = ST_REPLAY;
          end
        end
      end

      ST_REPLAY: begin
        if (live_dllp) begin
          pend_valid_d = 1'b1;
          pend_type_d  = dllp_type;
          pend_seq_d   = dllp_seq;
        end
        rb_ack_nak_d    = DLLP_NAK;
        rb_seq_d        = rp_q;
        replay_active_d = 1'b1;
        if (rp_q == next_seq_q - SEQ_W'(1)) state_d = ST_SEND;
        else                                rp_d    = rp_q + SEQ_W'(1);
      end

      ST_RETRAIN: begin
        if (live_dllp) begin
          pend_valid_d = 1'b1;
          pend_type_d  = dllp_type;
          pend_seq_d   = dllp_seq;
        end
        retrain_req_d = 1'b1;
        if (retrain_done) begin
          retrain_req_d = 1'b0;
          replay_num_d  = '0;
          rp_d          = ackd_seq_q + SEQ_W'(1);
          state_d       = (rp_d != next_seq_q) ? ST_REPLAY : ST_SEND;
        end
      end

      default: begin
        state_d = ST_SEND;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_SEND;
      next_seq_q      <= '0;
      ackd_seq_q      <= '1;
      rp_q            <= '0;
      replay_num_q    <= '0;
      pend_valid_q    <= 1'b0;
      pend_type_q     <= '0;
      pend_seq_q      <= '0;
      rb_we_q         <= 1'b0;
      rb_seq_q        <= '0;
      rb_din_q        <= '0;
      rb_ack_nak_q    <= '0;
      rb_timeout_q    <= 1'b0;
      retrain_req_q   <= 1'b0;
      replay_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      next_seq_q      <= next_seq_d;
      ackd_seq_q      <= ackd_seq_d;
      rp_q            <= rp_d;
      replay_num_q    <= replay_num_d;
      pend_valid_q    <= pend_valid_d;
      pend_type_q     <= pend_type_d;
      pend_seq_q      <= pend_seq_d;
      rb_we_q         <= rb_we_d;
      rb_seq_q        <= rb_seq_d;
      rb_din_q        <= rb_din_d;
      rb_ack_nak_q    <= rb_ack_nak_d;
      rb_timeout_q    <= rb_timeout_d;
      retrain_req_q   <= retrain_req_d;
      replay_active_q <= replay_active_d;
    end
  end

  assign rb_we          = rb_we_q;
  assign rb_seq         = rb_seq_q;
  assign rb_din         = rb_din_q;
  assign rb_ack_nak     = rb_ack_nak_q;
  assign rb_timeout     = rb_timeout_q;
  assign retrain_req    = retrain_req_q;
  assign replay_active  = replay_active_q;
  assign unacked        = unacked_full[10:0];
  assign dbg_state      = state_q;
  assign dbg_replay_num = replay_num_q;

endmodule

// File: tb/tb_dll_tx_seq_ctrl.sv
// Directed bench for dll_tx_seq_ctrl: write numbering, ACK/NAK handling,
// replay timer escalation to retrain, sequence wrap, fill limit, async reset.
module tb_dll_tx_seq_ctrl;
  import dll_pkg::*;

  localparam int DATA_W = 64;
  localparam int SEQ_W  = 12;

  logic              clk;
  logic              reset_n;
  logic              tlp_valid;
  logic [DATA_W-1:0] tlp_data;
  logic              tlp_ready;
  logic              dllp_valid;
  logic [1:0]        dllp_type;
  logic [SEQ_W-1:0]  dllp_seq;
  logic              retrain_done;
  logic              rb_we;
  logic [SEQ_W-1:0]  rb_seq;
  logic [DATA_W-1:0] rb_din;
  logic [1:0]        rb_ack_nak;
  logic              rb_timeout;
  logic              retrain_req;
  logic              replay_active;
  logic [10:0]       unacked;
  logic [1:0]        dbg_state;
  logic [1:0]        dbg_replay_num;

  int n_vec = 0;
  int n_err = 0;
  logic [SEQ_W-1:0] exp_q[$];

  dll_tx_seq_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tlp_valid      (tlp_valid),
    .tlp_data       (tlp_data),
    .tlp_ready      (tlp_ready),
    .dllp_valid     (dllp_valid),
    .dllp_type      (dllp_type),
    .dllp_seq       (dllp_seq),
    .retrain_done   (retrain_done),
    .rb_we          (rb_we),
    .rb_seq         (rb_seq),
    .rb_din         (rb_din),
    .rb_ack_nak     (rb_ack_nak),
    .rb_timeout     (rb_timeout),
    .retrain_req    (retrain_req),
    .replay_active  (replay_active),
    .unacked        (unacked),
    .dbg_state      (dbg_state),
    .dbg_replay_num (dbg_replay_num)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit (%0d vectors, %0d miscompares)", n_vec, n_err);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock, then settle past the edge before anyone samples.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    tlp_valid    = 1'b0;
    tlp_data     = '0;
    dllp_valid   = 1'b0;
    dllp_type    = 2'b00;
    dllp_seq     = '0;
    retrain_done = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic send_dllp(input logic [1:0] t, input logic [SEQ_W-1:0] s);
    dllp_valid = 1'b1;
    dllp_type  = t;
    dllp_seq   = s;
    step();
    dllp_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ready"},   64'(tlp_ready),     64'd1);
    check_val({tag, "_we"},      64'(rb_we),         64'd0);
    check_val({tag, "_seq"},     64'(rb_seq),        64'd0);
    check_val({tag, "_din"},     rb_din,             64'd0);
    check_val({tag, "_acknak"},  64'(rb_ack_nak),    64'd0);
    check_val({tag, "_timeout"}, 64'(rb_timeout),    64'd0);
    check_val({tag, "_retrain"}, 64'(retrain_req),   64'd0);
    check_val({tag, "_ractive"}, 64'(replay_active), 64'd0);
    check_val({tag, "_unacked"}, 64'(unacked),       64'd0);
  endtask

  initial begin
    int n;
    int we_cnt;

    // Reset values.
    do_reset();
    reset_n = 1'b0;
    step();
    check_idle_outputs("rst");
    reset_n = 1'b1;

    // Three TLPs get sequence numbers 0, 1, 2 on successive writes.
    for (int i = 0; i < 3; i++) begin
      tlp_valid = 1'b1;
      tlp_data  = 64'hD000 + 64'(i);
      exp_q.push_back(12'(i));
      step();
      check_val("t3_we",  64'(rb_we), 64'd1);
      check_val("t3_seq", 64'(rb_seq), 64'(exp_q.pop_front()));
      check_val("t3_din", rb_din, 64'hD000 + 64'(i));
    end
    tlp_valid = 1'b0;
    step();
    check_val("t3_we_off",  64'(rb_we),   64'd0);
    check_val("t3_unacked", 64'(unacked), 64'd3);

    // ACK 1 retires two, duplicate ACK is a no-op, out-of-window ACK is dropped.
    send_dllp(DLLP_ACK, 12'd1);
    check_val("ack1_unacked", 64'(unacked), 64'd1);
    send_dllp(DLLP_ACK, 12'd1);
    check_val("dup_ack_unacked", 64'(unacked), 64'd1);
    send_dllp(DLLP_ACK, 12'd7);
    check_val("bad_ack_unacked", 64'(unacked), 64'd1);
    check_val("bad_ack_ready", 64'(tlp_ready), 64'd1);

    // Five TLPs then NAK 1: replay 2, 3, 4; an ACK parked during replay lands afterwards.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tlp_valid = 1'b1;
      tlp_data  = 64'hE000 + 64'(i);
      step();
    end
    tlp_valid = 1'b0;
    send_dllp(DLLP_NAK, 12'd1);
    check_val("nak_state",   64'(dbg_state),      64'(ST_REPLAY));
    check_val("nak_rnum",    64'(dbg_replay_num), 64'd1);
    check_val("nak_unacked", 64'(unacked),        64'd3);
    check_val("nak_ract0",   64'(replay_active),  64'd0);
    exp_q.push_back(12'd2);
    exp_q.push_back(12'd3);
    exp_q.push_back(12'd4);
    step();
    check_val("rp0_acknak", 64'(rb_ack_nak),    64'h2);
    check_val("rp0_seq",    64'(rb_seq),        64'(exp_q.pop_front()));
    check_val("rp0_ract",   64'(replay_active), 64'd1);
    check_val("rp0_ready",  64'(tlp_ready),     64'd0);
    check_val("rp0_we",     64'(rb_we),         64'd0);
    send_dllp(DLLP_ACK, 12'd3);
    check_val("rp1_seq",    64'(rb_seq),        64'(exp_q.pop_front()));
    check_val("rp1_acknak", 64'(rb_ack_nak),    64'h2);
    step();
    check_val("rp2_seq",    64'(rb_seq),        64'(exp_q.pop_front()));
    check_val("rp2_ract",   64'(replay_active), 64'd1);
    step();
    check_val("rp_end_ract",    64'(replay_active),  64'd0);
    check_val("rp_end_acknak",  64'(rb_ack_nak),     64'd0);
    check_val("pend_ack_unack", 64'(unacked),        64'd1);
    check_val("pend_ack_rnum",  64'(dbg_replay_num), 64'd0);

    // One unacked TLP: timeouts every REPLAY_TIMER_LIMIT cycles, fourth one retrains.
    do_reset();
    tlp_valid = 1'b1;
    tlp_data  = 64'hF00D;
    step();
    tlp_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (rb_timeout !== 1'b1 && n < 2000);
      check_val($sformatf("to%0d_cycles", k), 64'(n), 64'd711);
      check_val($sformatf("to%0d_rnum", k), 64'(dbg_replay_num), (k < 4) ? 64'(k) : 64'd3);
      check_val($sformatf("to%0d_retrain", k), 64'(retrain_req), (k == 4) ? 64'd1 : 64'd0);
      if (k < 4) begin
        step();
        check_val($sformatf("to%0d_rp_acknak", k), 64'(rb_ack_nak), 64'h2);
        check_val($sformatf("to%0d_rp_seq", k),    64'(rb_seq),     64'd0);
      end
    end
    step();
    step();
    check_val("rt_hold_req", 64'(retrain_req), 64'd1);
    check_val("rt_ready",    64'(tlp_ready),   64'd0);
    check_val("rt_no_to",    64'(rb_timeout),  64'd0);
    retrain_done = 1'b1;
    step();
    retrain_done = 1'b0;
    check_val("rt_done_req",  64'(retrain_req),    64'd0);
    check_val("rt_done_rnum", 64'(dbg_replay_num), 64'd0);
    step();
    check_val("rt_rp_acknak", 64'(rb_ack_nak),    64'h2);
    check_val("rt_rp_seq",    64'(rb_seq),        64'd0);
    check_val("rt_rp_ract",   64'(replay_active), 64'd1);
    step();
    check_val("rt_rp_done", 64'(replay_active), 64'd0);

    // Stream 4094 TLPs, each acking its predecessor, then wrap 4094 -> 1.
    do_reset();
    we_cnt = 0;
    for (int i = 0; i < 4094; i++) begin
      tlp_valid  = 1'b1;
      tlp_data   = 64'(i);
      dllp_valid = (i > 0);
      dllp_type  = DLLP_ACK;
      dllp_seq   = 12'(i - 1);
      step();
      if (rb_we === 1'b1) we_cnt++;
    end
    check_val("stream_we_cnt", 64'(we_cnt), 64'd4094);
    exp_q.push_back(12'd4094);
    exp_q.push_back(12'd4095);
    exp_q.push_back(12'd0);
    exp_q.push_back(12'd1);
    for (int i = 0; i < 4; i++) begin
      tlp_valid  = 1'b1;
      tlp_data   = 64'hAB00 + 64'(i);
      dllp_valid = (i == 0);
      dllp_type  = DLLP_ACK;
      dllp_seq   = 12'd4093;
      step();
      check_val($sformatf("wrap%0d_we", i),  64'(rb_we),  64'd1);
      check_val($sformatf("wrap%0d_seq", i), 64'(rb_seq), 64'(exp_q.pop_front()));
    end
    tlp_valid  = 1'b0;
    dllp_valid = 1'b0;
    send_dllp(DLLP_ACK, 12'd0);
    check_val("wrap_ack0_unacked", 64'(unacked), 64'd1);

    // Fill to DEPTH (ACK 0 midway keeps the timer quiet), then release one slot.
    do_reset();
    for (int i = 0; i <= 1024; i++) begin
      tlp_valid  = 1'b1;
      tlp_data   = 64'h5000 + 64'(i);
      dllp_valid = (i == 600);
      dllp_type  = DLLP_ACK;
      dllp_seq   = 12'd0;
      step();
      if (i == 1023) begin
        check_val("fill_1023_ready",   64'(tlp_ready), 64'd1);
        check_val("fill_1023_unacked", 64'(unacked),   64'd1023);
      end
    end
    dllp_valid = 1'b0;
    check_val("fill_full_seq",     64'(rb_seq),    64'd1024);
    check_val("fill_full_unacked", 64'(unacked),   64'd1024);
    check_val("fill_full_ready",   64'(tlp_ready), 64'd0);
    step();
    check_val("fill_stall_we",      64'(rb_we),   64'd0);
    check_val("fill_stall_unacked", 64'(unacked), 64'd1024);
    tlp_valid = 1'b0;
    send_dllp(DLLP_ACK, 12'd1);
    check_val("fill_ack_ready",   64'(tlp_ready), 64'd1);
    check_val("fill_ack_unacked", 64'(unacked),   64'd1023);

    // Asynchronous reset in the middle of a replay.
    send_dllp(DLLP_NAK, 12'd1);
    step();
    check_val("mid_rp_ract", 64'(replay_active), 64'd1);
    check_val("mid_rp_seq",  64'(rb_seq),        64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check_val("async_rst_state", 64'(dbg_state), 64'(ST_SEND));
    step();
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
